// File: rtl/rgb_capture_gray_frontend_if.sv
// Camera-side and downstream-store signals of the RGB capture / grayscale front end.
// The slave modport is the front end; the master modport is its environment.
interface rgb_capture_gray_frontend_if;
    logic       start;
    logic       clear;
    logic [7:0] camera_data;
    logic       data_valid;
    logic       RWM_2_done;
    logic       camera_enable;
    logic       RWM_2_enable;
    logic       rw_2;
    logic [7:0] GS_data;
    logic       GS_valid;
    logic       GS_done;

    modport master (
        output start, clear, camera_data, data_valid, RWM_2_done,
        input  camera_enable, RWM_2_enable, rw_2, GS_data, GS_valid, GS_done
    );

    modport slave (
        input  start, clear, camera_data, data_valid, RWM_2_done,
        output camera_enable, RWM_2_enable, rw_2, GS_data, GS_valid, GS_done
    );
endinterface

// File: rtl/rgb_capture_gray_frontend.sv
// Captures one RGB frame into an internal byte store, then replays it through a
// luminance converter while sequencing the downstream frame store.
module rgb_capture_gray_frontend #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                      clk,
    input  logic                      rst_n,
    rgb_capture_gray_frontend_if.slave bus,
    output logic [1:0]                seq_state
);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NBYTE = 3 * NPIX;
    localparam int AW    = $clog2(NBYTE + 1);
    localparam int IW    = $clog2(NBYTE);
    localparam int PW    = $clog2(NPIX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        CONVERT = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t state, next_state;
    logic   rwm1_en, rw_1, gs_en;
    logic   n_camera_enable, n_rwm1_en, n_rw_1, n_gs_en, n_rwm2_en, n_rw_2;

    logic [7:0]    mem [NBYTE];
    logic [AW-1:0] wa, ra;
    logic [7:0]    rwm1_data;
    logic          rwm1_valid, wr_done, rd_done, rwm1_done, pause;
    logic          do_write, do_read;

    logic [1:0]    phase;
    logic [7:0]    r_q, g_q;
    logic [PW-1:0] pix;
    logic [15:0]   luma;

    assign seq_state = state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start)      next_state = CAPTURE;
            CAPTURE: if (rwm1_done)      next_state = CONVERT;
            CONVERT: if (bus.GS_done)    next_state = OUTPUT;
            OUTPUT:  if (bus.RWM_2_done) next_state = IDLE;
            default:                     next_state = IDLE;
        endcase

        // Outputs are decoded from the next state so they register with the state.
        n_camera_enable = 1'b0;
        n_rwm1_en       = 1'b0;
        n_rw_1          = 1'b0;
        n_gs_en         = 1'b0;
        n_rwm2_en       = 1'b0;
        n_rw_2          = 1'b0;
        case (next_state)
            CAPTURE: begin
                n_camera_enable = 1'b1;
                n_rwm1_en       = 1'b1;
                n_rw_1          = 1'b1;
            end
            CONVERT: begin
                n_rwm1_en = 1'b1;
                n_gs_en   = 1'b1;
                n_rwm2_en = 1'b1;
                n_rw_2    = 1'b1;
            end
            OUTPUT:  n_rwm2_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state             <= IDLE;
            bus.camera_enable <= 1'b0;
            rwm1_en           <= 1'b0;
            rw_1              <= 1'b0;
            gs_en             <= 1'b0;
            bus.RWM_2_enable  <= 1'b0;
            bus.rw_2          <= 1'b0;
        end else begin
            state             <= next_state;
            bus.camera_enable <= n_camera_enable;
            rwm1_en           <= n_rwm1_en;
            rw_1              <= n_rw_1;
            gs_en             <= n_gs_en;
            bus.RWM_2_enable  <= n_rwm2_en;
            bus.rw_2          <= n_rw_2;
        end
    end

    assign do_write  = rwm1_en && rw_1 && bus.data_valid && (wa < AW'(NBYTE));
    assign do_read   = rwm1_en && !rw_1 && !pause && (ra < AW'(NBYTE));
    assign rwm1_done = wr_done | rd_done;

    always_ff @(posedge clk) begin
        if (do_write) mem[wa[IW-1:0]] <= bus.camera_data;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wa         <= '0;
            ra         <= '0;
            wr_done    <= 1'b0;
            rd_done    <= 1'b0;
            rwm1_valid <= 1'b0;
            rwm1_data  <= 8'd0;
        end else begin
            wr_done    <= do_write && (wa == AW'(NBYTE - 1));
            rd_done    <= rwm1_en && !rw_1 && rwm1_valid && (ra == AW'(NBYTE));
            rwm1_valid <= do_read;
            if (do_read) rwm1_data <= mem[ra[IW-1:0]];
            if (bus.clear || !rwm1_en) begin
                wa <= '0;
                ra <= '0;
            end else begin
                if (do_write) wa <= wa + 1'b1;
                if (do_read)  ra <= ra + 1'b1;
            end
        end
    end

    // Weights sum to 256, so the top byte of the 16-bit sum never overflows.
    assign luma = 16'd77 * {8'd0, r_q} + 16'd150 * {8'd0, g_q} + 16'd29 * {8'd0, rwm1_data};

    always_ff @(posedge clk) begin
        if (rst_n || !gs_en) begin
            phase        <= 2'd0;
            r_q          <= 8'd0;
            g_q          <= 8'd0;
            pix          <= '0;
            pause        <= 1'b0;
            bus.GS_data  <= 8'd0;
            bus.GS_valid <= 1'b0;
            bus.GS_done  <= 1'b0;
        end else begin
            bus.GS_valid <= 1'b0;
            bus.GS_done  <= 1'b0;
            pause        <= 1'b0;
            if (rwm1_valid) begin
                case (phase)
                    2'd0: begin
                        r_q   <= rwm1_data;
                        phase <= 2'd1;
                    end
                    2'd1: begin
                        g_q   <= rwm1_data;
                        phase <= 2'd2;
                    end
                    default: begin
                        bus.GS_data  <= luma[15:8];
                        bus.GS_valid <= 1'b1;
                        pause        <= 1'b1;
                        phase        <= 2'd0;
                    end
                endcase
            end
            if (bus.GS_valid) begin
                if (pix == PW'(NPIX - 1)) begin
                    pix         <= '0;
                    bus.GS_done <= 1'b1;
                end else begin
                    pix <= pix + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rgb_capture_gray_frontend.sv
// Directed bench for rgb_capture_gray_frontend on a 2x2 frame: capture, grayscale
// output, sequencing of the downstream store, clear and mid-frame reset.
module tb_rgb_capture_gray_frontend;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] seq_state;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         last_gs_cyc = -100;
  int         done_cnt = 0;
  logic [7:0] exp_q[$];

  rgb_capture_gray_frontend_if ifc();

  rgb_capture_gray_frontend #(.IMG_W(2), .IMG_H(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifc),
    .seq_state (seq_state)
  );

  // clock / reset-independent cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: every GS_valid pops one expected luminance byte
  always @(negedge clk) begin
    if (ifc.GS_valid) begin
      if (exp_q.size() == 0) begin
        check("gs_extra_pulse", ifc.GS_valid, 0);
      end else begin
        check("gs_data", ifc.GS_data, exp_q.pop_front());
      end
      if (cyc - last_gs_cyc < 20) check("gs_spacing", cyc - last_gs_cyc, 4);
      last_gs_cyc = cyc;
    end
    if (ifc.GS_done) begin
      check("gs_done_latency", cyc - last_gs_cyc, 1);
      done_cnt++;
    end
  end

  task automatic check_all_idle(input string tag);
    check({tag, "_state"}, seq_state, 0);
    check({tag, "_camera_enable"}, ifc.camera_enable, 0);
    check({tag, "_rwm2_enable"}, ifc.RWM_2_enable, 0);
    check({tag, "_rw_2"}, ifc.rw_2, 0);
    check({tag, "_gs_valid"}, ifc.GS_valid, 0);
    check({tag, "_gs_data"}, ifc.GS_data, 0);
    check({tag, "_gs_done"}, ifc.GS_done, 0);
  endtask

  task automatic pulse_start();
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  task automatic run_capture(input logic [7:0] bytes [12]);
    for (int i = 0; i < 12; i++) begin
      ifc.data_valid  = 1'b1;
      ifc.camera_data = bytes[i];
      @(negedge clk);
      if (i % 3 == 1) begin
        ifc.data_valid  = 1'b0;
        ifc.camera_data = 8'hAA;
        @(negedge clk);
      end
    end
    check("last_byte_state", seq_state, 1);
    // one more byte after the frame is complete must be ignored
    ifc.camera_data = 8'hEE;
    @(negedge clk);
    ifc.data_valid = 1'b0;
    check("convert_state", seq_state, 2);
    check("convert_camera_enable", ifc.camera_enable, 0);
    check("convert_rwm2_enable", ifc.RWM_2_enable, 1);
    check("convert_rw_2", ifc.rw_2, 1);
  endtask

  task automatic finish_frame(input int exp_done);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ifc.GS_done) break;
    end
    check("gs_done_seen", ifc.GS_done, 1);
    @(negedge clk);
    check("output_state", seq_state, 3);
    check("output_rwm2_enable", ifc.RWM_2_enable, 1);
    check("output_rw_2", ifc.rw_2, 0);
    check("output_gs_done_once", ifc.GS_done, 0);
    check("frame_remaining", exp_q.size(), 0);
    check("done_count", done_cnt, exp_done);
    ifc.RWM_2_done = 1'b1;
    @(negedge clk);
    ifc.RWM_2_done = 1'b0;
    check_all_idle("back_to_idle");
  endtask

  logic [7:0] f1 [12] = '{8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0,
                          8'd100, 8'd50, 8'd200, 8'd255, 8'd0, 8'd0};
  logic [7:0] f2 [12] = '{8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255,
                          8'd10, 8'd20, 8'd30, 8'd200, 8'd100, 8'd50};
  logic [7:0] f3 [12] = '{8'd50, 8'd100, 8'd150, 8'd128, 8'd128, 8'd128,
                          8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0};

  initial begin
    ifc.start = 1'b0;
    ifc.clear = 1'b0;
    ifc.camera_data = 8'd0;
    ifc.data_valid = 1'b0;
    ifc.RWM_2_done = 1'b0;
    repeat (3) @(negedge clk);
    check_all_idle("reset");
    rst_n = 1'b0;
    @(negedge clk);
    check("idle_without_start", seq_state, 0);

    // frame 1: white, black, mixed, red
    exp_q.push_back(8'd255); exp_q.push_back(8'd0);
    exp_q.push_back(8'd82);  exp_q.push_back(8'd76);
    pulse_start();
    check("start_camera_enable", ifc.camera_enable, 1);
    check("start_state", seq_state, 1);
    pulse_start();
    check("start_in_capture_ignored", seq_state, 1);
    ifc.RWM_2_done = 1'b1;
    @(negedge clk);
    ifc.RWM_2_done = 1'b0;
    check("stray_done_ignored", seq_state, 1);
    check("stray_done_camera_enable", ifc.camera_enable, 1);
    run_capture(f1);
    finish_frame(1);

    // frame 2: garbage then clear, so the real frame must land at address 0
    exp_q.push_back(8'd149); exp_q.push_back(8'd28);
    exp_q.push_back(8'd18);  exp_q.push_back(8'd124);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      ifc.data_valid  = 1'b1;
      ifc.camera_data = 8'(8'h33 + i);
      @(negedge clk);
    end
    ifc.data_valid = 1'b0;
    ifc.clear = 1'b1;
    @(negedge clk);
    ifc.clear = 1'b0;
    check("clear_keeps_capture", seq_state, 1);
    run_capture(f2);
    finish_frame(2);

    // frame 3 aborted by reset early in the conversion
    pulse_start();
    run_capture(f3);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    check_all_idle("mid_convert_reset");
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("post_abort_no_done", done_cnt, 2);

    // frame 4 recaptures frame 1 content over the aborted frame
    exp_q.push_back(8'd255); exp_q.push_back(8'd0);
    exp_q.push_back(8'd82);  exp_q.push_back(8'd76);
    pulse_start();
    check("restart_state", seq_state, 1);
    run_capture(f1);
    finish_frame(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/rgb_capture_gray_frontend.md
# rgb_capture_gray_frontend

Front end of the image pipeline: a sequencer sets a frame store to write mode and captures one RGB frame from the camera interface. It then reads the frame back through a grayscale converter and streams one 8-bit luminance byte per pixel to the downstream frame store (RWM_2), which it also sequences. It combines the sequencer, the RGB frame store (RWM_1) and the grayscaler; RWM_2 and the edge/keypoint stages sit outside.

## Interface
Parameters:
- IMG_W, 640, pixels per line
- IMG_H, 480, lines per frame
- Derived: NPIX = IMG_W*IMG_H; NBYTE = 3*NPIX (RGB byte order R,G,B per pixel)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-high (asserted = 1) despite the name
- start  in  1  one-cycle pulse, starts a frame; honoured only in IDLE
- clear  in  1  synchronous clear of RWM_1 address counters (contents kept)
- camera_data  in  8  camera byte stream
- data_valid  in  1  camera_data qualifier
- RWM_2_done  in  1  downstream store finished current phase (pulse)
- camera_enable  out  1  request camera streaming
- RWM_2_enable  out  1  downstream store enable
- rw_2  out  1  downstream mode: 1 = write, 0 = read
- GS_data  out  8  grayscale pixel
- GS_valid  out  1  GS_data qualifier, one-cycle per pixel
- GS_done  out  1  one-cycle pulse after last pixel of frame

## Operation
- Sequencer states: IDLE -> CAPTURE (on start) -> CONVERT (on RWM_1_done) -> OUTPUT (on GS_done) -> IDLE (on RWM_2_done).
- Outputs per state (registered, Moore): IDLE all 0; CAPTURE camera_enable=1, RWM_1 enable=1 rw_1=1; CONVERT RWM_1 enable=1 rw_1=0, GS enable=1, RWM_2_enable=1 rw_2=1; OUTPUT RWM_2_enable=1 rw_2=0.
- RWM_1: NBYTE×8 array; write counter and read counter, each 0..NBYTE.
  - Write (enable, rw_1=1): on data_valid, mem[wa]<=camera_data, wa++. Done pulse when wa reaches NBYTE; further writes ignored.
  - Read (enable, rw_1=0, pause=0, ra<NBYTE): RWM_1_data<=mem[ra], RWM_1_valid<=1, ra++; else valid<=0. Done pulse the cycle after the last valid byte.
  - Counters reset to 0 on reset, clear, or when enable deasserts.
- Grayscaler (enabled): byte phase counter 0/1/2 on RWM_1_valid; latch R, G; on B, GS_data<=(77*R+150*G+29*B)>>8 computed in 16 bits (max 255, no saturation needed), GS_valid<=1, pause<=1 for that same cycle. Never drops a byte arriving while pause is high.
- Pixel counter increments on each GS_valid; GS_done pulses the cycle after the NPIX-th GS_valid; counters return to 0.

## Timing
- Reset: state IDLE; all outputs, pause, valids, counters = 0; memory not cleared.
- start→camera_enable: 1 cycle.
- RWM_1 read latency 1 cycle; pause sampled in the same cycle as the read decision.
- Grayscale latency: GS_valid 1 cycle after the B byte's RWM_1_valid.
- Throughput: 3 bytes / 4 cycles (one pause cycle per pixel).
- start outside IDLE is ignored.
- Reset mid-frame aborts to IDLE in the next cycle.
- clear during CAPTURE restarts the write address at 0.
- A done pulse arriving in a non-matching state is ignored.

## Test plan
- IMG_W=2, IMG_H=2: reset held 3 cycles -> all outputs 0, state IDLE; start -> camera_enable=1 next cycle.
- Stream 12 bytes with data_valid gaps -> exactly 12 writes, RWM_1_done once, state CONVERT, camera_enable=0.
- Pixels (255,255,255),(0,0,0),(100,50,200),(255,0,0) -> GS_data 255, 0, 82, 76 in order, 4 GS_valid pulses spaced 4 cycles, GS_done once.
- Pixels (0,255,0),(0,0,255) -> 149, 28; verify no lost/duplicated byte across pause cycles.
- GS_done -> RWM_2_enable=1 rw_2=0; RWM_2_done pulse -> IDLE, all outputs 0; start pulses during CAPTURE ignored.
- Reset asserted mid-CONVERT -> IDLE next cycle. New start recaptures from address 0 -> correct gray output.
